adc_iq_pack: RTL and testbench
==============================

Name: adc_iq_pack

Overview:
- Sits directly downstream of the AD9361 LVDS interface and consumes its adc_valid/adc_data/adc_status/adc_r1_mode outputs.
- Sign-extends the 12-bit I/Q samples to 16 bits and packs them into 64-bit words.
- Buffers the words in a small FIFO and presents them on a valid/ready stream to the DMA/capture path.
- Detects and counts overflow when the consumer stalls.

Parameters:
FIFO_DEPTH, 8, number of 64-bit entries in the output FIFO; power of two, 4..64
FIFO_AW, 3, log2(FIFO_DEPTH); must match FIFO_DEPTH

Ports:
clk  input  1  interface clock, same domain as adc_valid/adc_data
rst_n  input  1  asynchronous active-low reset
en  input  1  capture enable; low = packer idle and FIFO flushed
adc_valid  input  1  one beat of adc_data valid this cycle
adc_data  input  48  {Q1[47:36], I1[35:24], Q0[23:12], I0[11:0]}, two's complement
adc_status  input  1  interface locked/healthy; low = beats discarded
adc_r1_mode  input  1  1 = 1R1T (channel 0 only), 0 = 2R2T
m_valid  output  1  m_data holds a valid word
m_data  output  64  packed word
m_ready  input  1  consumer accepts word when m_valid & m_ready
fifo_level  output  FIFO_AW+1  current FIFO occupancy
ovf  output  1  sticky overflow flag
ovf_cnt  output  16  dropped-word count, saturates at 0xFFFF
ovf_clr  input  1  single-cycle pulse; clears ovf and ovf_cnt

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: m_valid=0, m_data=0, fifo_level=0, ovf=0, ovf_cnt=0.
  - Internal: packer state=IDLE, pack_valid=0, FIFO pointers=0.
- Beat acceptance: a beat is accepted when adc_valid & adc_status & en are all high at a rising edge.
- Sign extension: every 12-bit field becomes 16 bits by replicating bit 11, e.g. 0x800 -> 0xF800 and 0x7FF -> 0x07FF.
- 2R2T mode (adc_r1_mode=0):
  - Each accepted beat produces one word: m_data = {sxQ1, sxI1, sxQ0, sxI0}, with sxI0 in bits [15:0].
  - The packer stays in IDLE.
- 1R1T mode (adc_r1_mode=1): only adc_data[23:0] is used. Packer FSM:
  - IDLE + accepted beat: latch {sxQ0, sxI0} into the low 32 bits -> HALF. No word produced.
  - HALF + accepted beat: word = {sxQ0_new, sxI0_new, low32} -> IDLE.
- Packer abort: any of the following forces the packer to IDLE and discards the half word without counting it as overflow:
  - adc_r1_mode changes value (compared against a registered copy);
  - adc_status is low;
  - en is low.
- Pipeline and latency:
  - The packed word is registered (pack_valid) at the edge that accepts the completing beat.
  - The FIFO write happens at the next edge.
  - m_valid rises after that edge when the FIFO was empty.
  - Total latency is 2 clk from the completing adc_valid to m_valid.
- FIFO behaviour:
  - First-word-fall-through: m_data = head entry whenever m_valid=1.
  - m_data must not change while m_valid=1 and m_ready=0.
  - Pop when m_valid & m_ready.
  - fifo_level updates on the same edge as the push or pop; a simultaneous push and pop leaves it unchanged.
- Full condition:
  - If pack_valid arrives with fifo_level==FIFO_DEPTH and no pop in the same cycle, the word is dropped.
  - ovf is set the next cycle and ovf_cnt increments, saturating.
  - If a pop coincides with a push at full, the write is accepted and there is no overflow.
- ovf_clr:
  - Clears ovf and ovf_cnt at the next edge.
  - If a drop occurs in the same cycle, the drop wins: ovf=1, ovf_cnt=1.
- en deasserted:
  - The FIFO is flushed at the next edge: pointers equal, fifo_level=0, m_valid=0.
  - pack_valid is cleared.
  - ovf/ovf_cnt are held.
  - Re-enabling starts clean in IDLE.
- Empty FIFO: m_valid=0; m_ready is ignored.

Test Plan:
1. 2R2T, m_ready=1:
   - Stimulus: adc_data=0x7FF_800_123_FFF with one valid pulse.
   - Required: m_valid high for exactly 1 cycle, 2 clk after the pulse, with m_data=0x07FF_F800_0123_FFFF.
2. 1R1T, m_ready=1:
   - Stimulus: beats {Q0=0x001, I0=0x002} then {Q0=0x803, I0=0x004}.
   - Required: one word, m_data=0xF803_0004_0001_0002; no word after the first beat.
3. 1R1T abort:
   - Stimulus: one beat, then adc_status low for 1 cycle, then two beats.
   - Required: exactly one word, built from the last two beats only; ovf stays 0.
4. Overflow, FIFO_DEPTH=8, m_ready=0:
   - Stimulus: 11 2R2T beats.
   - Required: fifo_level=8, ovf=1, ovf_cnt=3.
   - Then raise m_ready: the 8 words drain in order as the first 8 inputs.
5. Full plus simultaneous pop:
   - Stimulus: with fifo_level=8, m_ready=1 in the same cycle a new word is pushed.
   - Required: fifo_level stays 8, ovf_cnt unchanged.
   - Then ovf_clr coincident with a drop: ovf=1, ovf_cnt=1.
6. Reset/en mid-operation:
   - Stimulus: with 5 words queued and the packer in HALF, drop en for 1 cycle.
   - Required: fifo_level=0, m_valid=0 next cycle; the next two 1R1T beats produce a clean word.
   - Stimulus: assert rst_n low asynchronously between edges.
   - Required: all outputs 0 immediately.

Source files
------------

// File: rtl/adc_iq_pack.sv
// Packs AD9361 12-bit I/Q beats into sign-extended 64-bit words and queues them
// in a first-word-fall-through FIFO with sticky overflow accounting.
module adc_iq_pack #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               adc_valid,
  input  logic [47:0]        adc_data,
  input  logic               adc_status,
  input  logic               adc_r1_mode,
  output logic               m_valid,
  output logic [63:0]        m_data,
  input  logic               m_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               ovf,
  output logic [15:0]        ovf_cnt,
  input  logic               ovf_clr
);

  typedef enum logic {IDLE, HALF} pk_state_t;

  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(FIFO_DEPTH);

  function automatic logic [15:0] sx12(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

  pk_state_t         state, state_nxt, state_eff;
  logic              r1_q;
  logic [31:0]       low32;
  logic              pack_valid;
  logic [63:0]       pack_data;
  logic              accept, abort;
  logic              word_fire, latch_lo;
  logic [63:0]       word;

  logic [63:0]        mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               pop, push, drop, full;

  assign accept = adc_valid & adc_status & en;
  // A mode flip, lost lock or disable silently throws away any half-built word.
  assign abort     = (adc_r1_mode != r1_q) | ~adc_status | ~en;
  assign state_eff = abort ? IDLE : state;

  // ---------------- packer FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      r1_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      r1_q  <= adc_r1_mode;
    end
  end

  always_comb begin
    state_nxt = state_eff;
    if (accept && adc_r1_mode)
      state_nxt = (state_eff == IDLE) ? HALF : IDLE;
  end

  always_comb begin
    word_fire = 1'b0;
    latch_lo  = 1'b0;
    word      = '0;
    if (accept) begin
      if (!adc_r1_mode) begin
        word_fire = 1'b1;
        word      = {sx12(adc_data[47:36]), sx12(adc_data[35:24]),
                     sx12(adc_data[23:12]), sx12(adc_data[11:0])};
      end else if (state_eff == IDLE) begin
        latch_lo = 1'b1;
      end else begin
        word_fire = 1'b1;
        word      = {sx12(adc_data[23:12]), sx12(adc_data[11:0]), low32};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low32      <= '0;
      pack_valid <= 1'b0;
      pack_data  <= '0;
    end else begin
      if (latch_lo) low32 <= {sx12(adc_data[23:12]), sx12(adc_data[11:0])};
      pack_valid <= word_fire;
      if (word_fire) pack_data <= word;
    end
  end

  // ---------------- output FIFO ----------------
  assign full    = (fifo_level == DEPTH_L);
  assign m_valid = (fifo_level != '0);
  assign pop     = m_valid & m_ready;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push    = pack_valid & (~full | pop);
  assign drop    = pack_valid & full & ~pop;
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (en && push) mem[wr_ptr] <= pack_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (!en) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;
    end
  end

  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf     <= 1'b0;
      ovf_cnt <= '0;
    end else if (en && drop) begin
      ovf     <= 1'b1;
      ovf_cnt <= ovf_clr ? 16'd1 : ((ovf_cnt == 16'hFFFF) ? ovf_cnt : ovf_cnt + 16'd1);
    end else if (ovf_clr) begin
      ovf     <= 1'b0;
      ovf_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_adc_iq_pack.sv
// Randomized + directed bench for adc_iq_pack: a queue-based reference model
// predicts every stored word; a negedge monitor pops and compares on handshake.
module tb_adc_iq_pack;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic        clk = 1'b0;
  logic        rst_n, en, adc_valid, adc_status, adc_r1_mode, m_ready, ovf_clr;
  logic [47:0] adc_data;
  logic        m_valid, ovf;
  logic [63:0] m_data;
  logic [AW:0] fifo_level;
  logic [15:0] ovf_cnt;

  adc_iq_pack #(.FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .adc_valid(adc_valid), .adc_data(adc_data),
    .adc_status(adc_status), .adc_r1_mode(adc_r1_mode), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .fifo_level(fifo_level), .ovf(ovf),
    .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sx(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

  // ---------------- reference model ----------------
  logic [63:0] exp_q[$];
  int          occ;
  bit          infl, half, prev_mode, m_ovf;
  logic [63:0] infl_d;
  logic [31:0] low_m;
  logic [15:0] m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ = 0; exp_q.delete(); infl = 0; half = 0; prev_mode = 0;
      m_ovf = 0; m_cnt = 0; low_m = 0; infl_d = 0;
    end else begin
      bit pop, drop;
      pop  = (occ != 0) && m_ready;
      drop = 0;
      if (!en) begin
        occ = 0; exp_q.delete();
      end else if (infl && (occ < DEPTH || pop)) begin
        exp_q.push_back(infl_d);
        if (!pop) occ++;
      end else begin
        if (infl) drop = 1;
        if (pop) occ--;
      end
      if (drop) begin
        m_ovf = 1;
        m_cnt = ovf_clr ? 16'd1 : (m_cnt == 16'hFFFF ? m_cnt : m_cnt + 16'd1);
      end else if (ovf_clr) begin
        m_ovf = 0; m_cnt = 0;
      end
      infl = 0;
      if (adc_r1_mode != prev_mode || !adc_status || !en) half = 0;
      if (adc_valid && adc_status && en) begin
        if (!adc_r1_mode) begin
          infl   = 1;
          infl_d = {sx(adc_data[47:36]), sx(adc_data[35:24]), sx(adc_data[23:12]), sx(adc_data[11:0])};
        end else if (!half) begin
          half  = 1;
          low_m = {sx(adc_data[23:12]), sx(adc_data[11:0])};
        end else begin
          half   = 0;
          infl   = 1;
          infl_d = {sx(adc_data[23:12]), sx(adc_data[11:0]), low_m};
        end
      end
      prev_mode = adc_r1_mode;
    end
  end

  // ---------------- monitor ----------------
  int          pops = 0;
  logic [63:0] last_pop = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_valid", {63'd0, m_valid}, {63'd0, occ != 0});
      chk("fifo_level", {60'd0, fifo_level}, 64'(occ));
      chk("ovf", {63'd0, ovf}, {63'd0, m_ovf});
      chk("ovf_cnt", {48'd0, ovf_cnt}, {48'd0, m_cnt});
      if (occ != 0 && exp_q.size() != 0) begin
        chk("m_data", m_data, exp_q[0]);
        if (m_ready) begin
          void'(exp_q.pop_front());
          pops++;
          last_pop = m_data;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [47:0] d);
    adc_valid = 1'b1; adc_data = d;
    step();
    adc_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [47:0] d4 [11];
  logic [63:0] r64;
  int          p0;

  initial begin
    rst_n = 1'b0; en = 1'b0; adc_valid = 1'b0; adc_data = '0; adc_status = 1'b0;
    adc_r1_mode = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
    #1;
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_level", {60'd0, fifo_level}, 64'd0);
    chk("rst_ovf", {47'd0, ovf, ovf_cnt}, 64'd0);
    #22 rst_n = 1'b1;
    en = 1'b1; adc_status = 1'b1; m_ready = 1'b1;
    idle(2);

    // 1: single 2R2T word, 2-cycle latency, one-cycle m_valid
    beat(48'h7FF_800_123_FFF);
    @(negedge clk); chk("t1_lat1", {63'd0, m_valid}, 64'd0);
    @(negedge clk); chk("t1_lat2", {63'd0, m_valid}, 64'd1);
    chk("t1_data", m_data, 64'h07FF_F800_0123_FFFF);
    @(negedge clk); chk("t1_once", {63'd0, m_valid}, 64'd0);
    #6;

    // 2: 1R1T pair
    adc_r1_mode = 1'b1; idle(2);
    p0 = pops;
    beat({24'h0, 12'h001, 12'h002});
    beat({24'h0, 12'h803, 12'h004});
    idle(4);
    chk("t2_count", 64'(pops - p0), 64'd1);
    chk("t2_word", last_pop, 64'hF803_0004_0001_0002);

    // 3: abort via status low
    p0 = pops;
    beat({24'h0, 12'h111, 12'h222});
    adc_status = 1'b0; step(); adc_status = 1'b1;
    beat({24'h0, 12'h333, 12'h844});
    beat({24'h0, 12'hA55, 12'h066});
    idle(4);
    chk("t3_count", 64'(pops - p0), 64'd1);
    chk("t3_word", last_pop, 64'hFA55_0066_0333_F844);
    chk("t3_ovf", {63'd0, ovf}, 64'd0);

    // 4: overflow with consumer stalled
    adc_r1_mode = 1'b0; m_ready = 1'b0; idle(2);
    for (int i = 0; i < 11; i++) begin
      r64 = {$urandom, $urandom};
      d4[i] = r64[47:0];
      beat(d4[i]);
    end
    idle(3);
    chk("t4_level", {60'd0, fifo_level}, 64'd8);
    chk("t4_ovf", {63'd0, ovf}, 64'd1);
    chk("t4_cnt", {48'd0, ovf_cnt}, 64'd3);
    p0 = pops;
    m_ready = 1'b1; idle(10);
    chk("t4_drained", 64'(pops - p0), 64'd8);
    chk("t4_last", last_pop, {sx(d4[7][47:36]), sx(d4[7][35:24]), sx(d4[7][23:12]), sx(d4[7][11:0])});

    // 5: push at full with simultaneous pop, then clear racing a drop
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) beat(48'(i * 7 + 1));
    idle(3);
    chk("t5_full", {60'd0, fifo_level}, 64'd8);
    beat(48'h0AB_0CD_0EF_012);
    m_ready = 1'b1; step(); m_ready = 1'b0;
    @(negedge clk);
    chk("t5_level", {60'd0, fifo_level}, 64'd8);
    chk("t5_cnt", {48'd0, ovf_cnt}, 64'd3);
    #6;
    beat(48'h123_456_789_ABC);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    @(negedge clk);
    chk("t5_clr_ovf", {63'd0, ovf}, 64'd1);
    chk("t5_clr_cnt", {48'd0, ovf_cnt}, 64'd1);
    #6;

    // 6: en drop with words queued and packer half-full
    m_ready = 1'b1; idle(12); m_ready = 1'b0;
    for (int i = 0; i < 5; i++) beat(48'(i + 100));
    adc_r1_mode = 1'b1; step();
    beat({24'h0, 12'h7AA, 12'h7BB});
    idle(1);
    chk("t6_level5", {60'd0, fifo_level}, 64'd5);
    en = 1'b0; step(); en = 1'b1;
    @(negedge clk);
    chk("t6_flush", {60'd0, fifo_level}, 64'd0);
    chk("t6_mvalid", {63'd0, m_valid}, 64'd0);
    #6;
    p0 = pops; m_ready = 1'b1;
    beat({24'h0, 12'h010, 12'h020});
    beat({24'h0, 12'hFFF, 12'h030});
    idle(4);
    chk("t6_count", 64'(pops - p0), 64'd1);
    chk("t6_word", last_pop, 64'hFFFF_0030_0010_0020);

    // random phase
    for (int c = 0; c < 1500; c++) begin
      r64 = {$urandom, $urandom};
      adc_data   = r64[47:0];
      adc_valid  = ($urandom % 4) != 0;
      adc_status = ($urandom % 16) != 0;
      en         = ($urandom % 60) != 0;
      ovf_clr    = ($urandom % 40) == 0;
      if ($urandom % 64 == 0) adc_r1_mode = ~adc_r1_mode;
      if ($urandom % 12 == 0) m_ready = ~m_ready;
      step();
    end
    adc_valid = 1'b0; ovf_clr = 1'b0; en = 1'b1; adc_status = 1'b1;
    adc_r1_mode = 1'b0; idle(2);

    // asynchronous reset between edges with words queued and overflow set
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) beat(48'(i + 500));
    idle(3);
    chk("pre_rst_ovf", {63'd0, ovf}, 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    chk("arst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("arst_m_data", m_data, 64'd0);
    chk("arst_level", {60'd0, fifo_level}, 64'd0);
    chk("arst_ovf", {47'd0, ovf, ovf_cnt}, 64'd0);
    #20;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
